traffic_gen_mc: RTL and testbench
=================================

Name: traffic_gen_mc

Overview:
Parametrised multi-channel stream traffic generator for bench and bring-up use. Emits valid/ready beats round-robin across NCH logical channels. Each channel has its own data sequence. Selectable pattern mode, a programmable inter-beat gap, a finite or infinite run length, start/abort control and a done pulse. Sits at the head of a stream datapath in place of a DMA or source block.

Parameters:
DW, 32, data width; legal values 8/16/32/64
NCH, 4, number of logical channels (1..16)
CNT_W, 16, width of the length and gap counters

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  pulse; latches cfg_* and begins a run; ignored while busy
abort  in  1  level/pulse; ends the run early
cfg_mode  in  2  0=increment, 1=constant, 2=LFSR, 3=walking-one
cfg_len  in  CNT_W  beats per run; 0=infinite
cfg_gap  in  CNT_W  idle cycles between beats
cfg_seed  in  DW  base seed
busy  out  1  run active
done  out  1  one-cycle pulse at end of run
down_valid  out  1  beat valid
down_ready  in  1  downstream ready
down_data  out  DW  beat payload
down_chan  out  max(1,$clog2(NCH))  channel of current beat
down_last  out  1  final beat of a finite run

Behaviour:
- Reset values: state IDLE; busy=0, done=0, down_valid=0, down_last=0, down_chan=0, down_data=0; counters 0.
- Handshake: beat transfers when down_valid && down_ready.
  - Once asserted, down_valid, down_data, down_chan and down_last stay stable until the transfer.
  - down_valid never depends combinationally on down_ready.
- FSM states: IDLE, SEND, GAP.
  - IDLE: start (and not rst) latches cfg_*, clears beat_cnt, sets chan=0, initialises all channel registers, sets busy=1, goes to SEND.
  - SEND: down_valid=1. On transfer: beat_cnt++, chan advances (NCH-1 wraps to 0), the sent channel's register advances. Then:
    - finite run and beat was last -> IDLE with done=1 next cycle;
    - else abort seen -> IDLE with done=1;
    - else cfg_gap>0 -> GAP with gap_cnt=0;
    - else stay in SEND, so back-to-back beats run at 1/cycle.
  - GAP: down_valid=0. gap_cnt increments every cycle, independent of ready. When gap_cnt==cfg_gap-1, go to SEND. abort in GAP -> IDLE with done=1.
- First valid appears the cycle after start.
- Abort in SEND never drops valid. The pending beat completes first, then the run ends.
- Channel initialisation at start, for channel c:
  - modes 0/1: cfg_seed + c;
  - mode 2: cfg_seed ^ c, replaced with all-ones if zero;
  - mode 3: 1 << (c mod DW).
- Channel advance per mode:
  - mode 0: +1 mod 2^DW (wraps from all-ones to 0);
  - mode 1: unchanged;
  - mode 2: one Galois LFSR step, taps from package per DW;
  - mode 3: rotate left by 1.
- down_last=1 only when cfg_len!=0 and beat_cnt==cfg_len-1. Never asserted for infinite or aborted runs.
- beat_cnt wraps silently in infinite mode.
- done and start on the same cycle: start is ignored, because busy is still set.
- rst has priority over start/abort. Reset mid-run returns to IDLE immediately; down_valid drops and no done pulse is issued.

Optional Feature:
TGEN_STALL_STATS_EN
- Defined: adds output stall_cnt[CNT_W].
  - Counts cycles with down_valid && !down_ready during the current run.
  - Saturates at all-ones; cleared at start and by rst.
  - Holds its value after done.
- Undefined: the port and the logic are absent; all other behaviour is identical.

Decomposition:
- Package traffic_gen_pkg holds:
  - mode enum (MODE_INC, MODE_CONST, MODE_LFSR, MODE_WALK);
  - FSM state enum;
  - function lfsr_taps(DW): 8'hB8, 16'hB400, 32'h80200003, 64'hD800000000000000;
  - function lfsr_step.
- Sub-module tgen_chan_seq holds one channel's data register plus init/advance logic, instantiated NCH times. Top level contains the FSM, counters and output mux.

Test Plan:
- Mode 0, NCH=4, seed=0x10, len=8, gap=0, ready=1:
  - data 0x10,0x11,0x12,0x13,0x11,0x12,0x13,0x14; chan 0,1,2,3,0,1,2,3;
  - last on beat 8; done one cycle later; 8 consecutive valid cycles.
- Mode 0, len=3, gap=2: valid pattern 1,0,0,1,0,0,1; done follows the third beat.
- Backpressure: ready random 50%. Payload is stable while valid&&!ready, no beats are lost or duplicated, and the per-channel sequences are correct.
- Mode 2, DW=32, seed=0: channel 0 starts at 0xFFFFFFFF and the sequence matches the golden LFSR over 1000 beats. Mode 3: channel 1 shows 0x2, 0x4, 0x8.
- len=0 plus abort, asserted once while valid&&!ready and once during GAP:
  - SEND case: the pending beat completes, then done; down_last stays 0.
  - GAP case: done next cycle with no further beat.
- rst mid-run at beat 5: valid low next cycle; no done pulse; start after reset restarts from the seed. Start while busy is ignored. With TGEN_STALL_STATS_EN defined and ready held low 7 cycles, stall_cnt=7.

Source files
------------

// File: rtl/traffic_gen_pkg.sv
// Shared types and LFSR helpers for the traffic_gen_mc stream generator.
package traffic_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_CONST = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [63:0] lfsr_taps(input int dw);
    case (dw)
      8:       return 64'hB8;
      16:      return 64'hB400;
      32:      return 64'h8020_0003;
      default: return 64'hD800_0000_0000_0000;
    endcase
  endfunction

  // Right-shifting Galois step; callers keep v within dw bits so the result does too.
  function automatic logic [63:0] lfsr_step(input logic [63:0] v, input int dw);
    return v[0] ? ((v >> 1) ^ lfsr_taps(dw)) : (v >> 1);
  endfunction

endpackage

// File: rtl/tgen_chan_seq.sv
// One channel's payload register: loads its start value on init, steps on adv.
module tgen_chan_seq
  import traffic_gen_pkg::*;
#(
  parameter int DW = 32,
  parameter int CH = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          adv,
  input  mode_e         mode,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] data
);

  logic [DW-1:0] data_q, data_d, init_val;

  always_comb begin
    init_val = seed + DW'(CH);
    case (mode)
      MODE_LFSR: begin
        init_val = seed ^ DW'(CH);
        // an all-zero state would lock the LFSR
        if (init_val == '0) init_val = '1;
      end
      MODE_WALK: init_val = DW'(1) << (CH % DW);
      default: ;
    endcase

    data_d = data_q;
    if (init) begin
      data_d = init_val;
    end else if (adv) begin
      case (mode)
        MODE_INC:  data_d = data_q + DW'(1);
        MODE_LFSR: data_d = DW'(lfsr_step(64'(data_q), DW));
        MODE_WALK: data_d = {data_q[DW-2:0], data_q[DW-1]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/traffic_gen_mc.sv
// Multi-channel round-robin stream traffic generator.
// Optional TGEN_STALL_STATS_EN adds a saturating stall_cnt output.
//
// state | meaning
// IDLE  | no run; waits for start (blocked during the done cycle)
// SEND  | down_valid high, holds the beat until accepted
// GAP   | idle for cfg_gap cycles between beats
module traffic_gen_mc
  import traffic_gen_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int NCH   = 4,
  parameter  int CNT_W = 16,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [DW-1:0]    cfg_seed,
  output logic             busy,
  output logic             done,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [DW-1:0]    down_data,
  output logic [CW-1:0]    down_chan,
  output logic             down_last
`ifdef TGEN_STALL_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, mode_sel;
  logic [CNT_W-1:0] len_q, len_d, gap_q, gap_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]    chan_q, chan_d;
  logic             done_q, done_d, abort_q, abort_d;
  logic             start_acc, xfer, last_beat;
  logic [DW-1:0]    chan_data [NCH];

  assign start_acc = (state_q == ST_IDLE) && !done_q && start;
  assign xfer      = (state_q == ST_SEND) && down_ready;
  assign last_beat = (len_q != '0) && (beat_cnt_q == len_q - CNT_W'(1));
  assign mode_sel  = start_acc ? mode_e'(cfg_mode) : mode_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    gap_d      = gap_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    chan_d     = chan_q;
    abort_d    = abort_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start_acc) begin
          mode_d     = mode_e'(cfg_mode);
          len_d      = cfg_len;
          gap_d      = cfg_gap;
          beat_cnt_d = '0;
          chan_d     = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // abort is remembered so the pending beat still completes
        if (abort) abort_d = 1'b1;
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          chan_d     = (chan_q == CW'(NCH - 1)) ? '0 : chan_q + CW'(1);
          if (last_beat || abort || abort_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + CNT_W'(1);
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == gap_q - CNT_W'(1)) begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_INC;
      len_q      <= '0;
      gap_q      <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      chan_q     <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      chan_q     <= chan_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    tgen_chan_seq #(.DW(DW), .CH(c)) u_seq (
      .clk  (clk),
      .rst  (rst),
      .init (start_acc),
      .adv  (xfer && (chan_q == CW'(c))),
      .mode (mode_sel),
      .seed (cfg_seed),
      .data (chan_data[c])
    );
  end

  // busy covers the done cycle so a start arriving with done is dropped
  assign busy       = (state_q != ST_IDLE) || done_q;
  assign done       = done_q;
  assign down_valid = (state_q == ST_SEND);
  assign down_data  = chan_data[chan_q];
  assign down_chan  = chan_q;
  assign down_last  = (state_q == ST_SEND) && last_beat;

`ifdef TGEN_STALL_STATS_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc)
      stall_q <= '0;
    else if ((state_q == ST_SEND) && !down_ready && (stall_q != '1))
      stall_q <= stall_q + CNT_W'(1);
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_traffic_gen_mc.sv
// Self-checking bench for traffic_gen_mc (DW=32, NCH=4) against a closed-form payload model.
module tb_traffic_gen_mc;

  localparam int DW    = 32;
  localparam int NCH   = 4;
  localparam int CNT_W = 16;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk, rst, start, abort, down_ready;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len, cfg_gap;
  logic [31:0] cfg_seed, down_data;
  logic        busy, done, down_valid, down_last;
  logic [1:0]  down_chan;
`ifdef TGEN_STALL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  traffic_gen_mc #(.DW(DW), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_mode   (cfg_mode),
    .cfg_len    (cfg_len),
    .cfg_gap    (cfg_gap),
    .cfg_seed   (cfg_seed),
    .busy       (busy),
    .done       (done),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_chan  (down_chan),
    .down_last  (down_last)
`ifdef TGEN_STALL_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_lfsr(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
  endfunction

  // n-th beat of the run goes to channel n%NCH and is that channel's (n/NCH)-th value
  function automatic logic [31:0] exp_val(input int mode, input logic [31:0] seed, input int n);
    int c, k, r;
    logic [31:0] v;
    c = n % NCH;
    k = n / NCH;
    case (mode)
      0: v = seed + 32'(c) + 32'(k);
      1: v = seed + 32'(c);
      2: begin
        v = seed ^ 32'(c);
        if (v == 32'h0) v = 32'hFFFF_FFFF;
        for (int i = 0; i < k; i++) v = ref_lfsr(v);
      end
      default: begin
        v = 32'h1 << (c % 32);
        r = k % 32;
        if (r != 0) v = (v << r) | (v >> (32 - r));
      end
    endcase
    return v;
  endfunction

  task automatic do_run(input int mode, input logic [31:0] seed, input int len, input int gap,
                        input int rdy_pct, input bit noise);
    int n, idle, cyc;
    bit stalled, after_x, exp_done, finished, rdy;
    logic [31:0] pd;
    logic [1:0]  pc;
    logic        pl;
    n = 0; idle = 0; cyc = 0;
    stalled = 0; after_x = 0; exp_done = 0; finished = 0;
    pd = '0; pc = '0; pl = 1'b0;
    @(negedge clk);
    cfg_mode = 2'(mode); cfg_seed = seed; cfg_len = 16'(len); cfg_gap = 16'(gap);
    start = 1'b1; down_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", 64'(down_valid), 64'd1);
    while (!finished && cyc < 20000) begin
      if (stalled) begin
        chk("hold_valid", 64'(down_valid), 64'd1);
        chk("hold_data", 64'(down_data), 64'(pd));
        chk("hold_chan", 64'(down_chan), 64'(pc));
        chk("hold_last", 64'(down_last), 64'(pl));
      end
      chk("done", 64'(done), 64'(exp_done));
      if (done) begin
        chk("beat_total", 64'(n), 64'(len));
        chk("done_valid", 64'(down_valid), 64'd0);
        finished = 1;
      end else begin
        exp_done = 0;
        if (noise) begin
          start = 1'($urandom); cfg_mode = 2'($urandom); cfg_seed = $urandom;
          cfg_len = 16'($urandom); cfg_gap = 16'($urandom);
        end
        rdy = (int'($urandom_range(99)) < rdy_pct);
        down_ready = rdy;
        if (!down_valid) begin
          idle++;
        end else begin
          if (after_x) begin
            chk("gap_len", 64'(idle), 64'(gap));
            after_x = 0;
          end
          if (rdy) begin
            chk("data", 64'(down_data), 64'(exp_val(mode, seed, n)));
            chk("chan", 64'(down_chan), 64'(n % NCH));
            chk("last", 64'(down_last), 64'(len != 0 && n == len - 1));
            exp_done = (len != 0 && n == len - 1);
            n++;
            after_x = !exp_done;
            idle = 0;
          end
        end
        stalled = down_valid && !rdy;
        pd = down_data; pc = down_chan; pl = down_last;
        @(negedge clk);
        cyc++;
      end
    end
    chk("run_finished", 64'(finished), 64'd1);
    // start during the done cycle must be dropped
    start = 1'b1; down_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_busy", 64'(busy), 64'd0);
    chk("start_at_done_valid", 64'(down_valid), 64'd0);
  endtask

  initial begin
    int m;
    logic [31:0] s;
    rst = 1'b1; start = 1'b0; abort = 1'b0; down_ready = 1'b0;
    cfg_mode = 2'd0; cfg_len = '0; cfg_gap = '0; cfg_seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(down_valid), 64'd0);
    chk("rst_last", 64'(down_last), 64'd0);
    chk("rst_chan", 64'(down_chan), 64'd0);
    chk("rst_data", 64'(down_data), 64'd0);
    rst = 1'b0;

    do_run(0, 32'h10, 8, 0, 100, 0);
    do_run(0, 32'h10, 3, 2, 100, 0);
    for (int i = 0; i < 3; i++) begin
      m = int'($urandom_range(3));
      do_run(m, $urandom, 40, int'($urandom_range(3)), 50, 1);
    end
    do_run(2, 32'h0, 1000, 0, 90, 0);
    do_run(3, 32'h5, 12, 1, 100, 0);
    do_run(0, 32'hFFFF_FFFE, 9, 0, 70, 0);
    do_run(1, $urandom, 10, 0, 60, 1);

    // abort while a beat is stalled: beat still completes, then done
    s = $urandom;
    @(negedge clk);
    cfg_mode = 2'd0; cfg_seed = s; cfg_len = 16'd0; cfg_gap = 16'd0;
    start = 1'b1; down_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("ab_send_valid0", 64'(down_valid), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_send_valid1", 64'(down_valid), 64'd1);
    chk("ab_send_nodone", 64'(done), 64'd0);
    @(negedge clk);
    chk("ab_send_valid2", 64'(down_valid), 64'd1);
    chk("ab_send_data", 64'(down_data), 64'(s));
    chk("ab_send_last", 64'(down_last), 64'd0);
    down_ready = 1'b1;
    @(negedge clk);
    down_ready = 1'b0;
    chk("ab_send_done", 64'(done), 64'd1);
    chk("ab_send_novalid", 64'(down_valid), 64'd0);
    @(negedge clk);
    chk("ab_send_pulse", 64'(done), 64'd0);
    chk("ab_send_idle", 64'(busy), 64'd0);

    // abort during the inter-beat gap: done next cycle, no further beat
    @(negedge clk);
    cfg_mode = 2'd0; cfg_seed = s; cfg_len = 16'd0; cfg_gap = 16'd5;
    start = 1'b1; down_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_gap_valid", 64'(down_valid), 64'd1);
    @(negedge clk);
    chk("ab_gap_in_gap", 64'(down_valid), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_gap_done", 64'(done), 64'd1);
    chk("ab_gap_novalid", 64'(down_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ab_gap_quiet", 64'(down_valid | done), 64'd0);
    end
    down_ready = 1'b0;

    // reset while beat 5 is pending
    s = $urandom;
    @(negedge clk);
    cfg_mode = 2'd0; cfg_seed = s; cfg_len = 16'd0; cfg_gap = 16'd0;
    start = 1'b1; down_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_beat5", 64'(down_data), 64'(exp_val(0, s, 4)));
    rst = 1'b1; down_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(down_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_nodone", 64'(done), 64'd0);
    end
    do_run(0, s, 6, 0, 100, 0);

`ifdef TGEN_STALL_STATS_EN
    @(negedge clk);
    cfg_mode = 2'd1; cfg_seed = 32'hA5; cfg_len = 16'd4; cfg_gap = 16'd0;
    start = 1'b1; down_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("stall_cleared", 64'(stall_cnt), 64'd0);
    repeat (7) @(negedge clk);
    down_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    chk("stall_run_done", 64'(done), 64'd1);
    down_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_cnt", 64'(stall_cnt), 64'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
